// File: rtl/serdes_lb_pkg.sv
// Shared definitions for the SERDES loopback incrementing byte pattern (01..08 wrapping).
package serdes_lb_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [7:0] PAT_MIN = 8'h01;
    localparam logic [7:0] PAT_MAX = 8'h08;

    function automatic logic [7:0] nxt_byte(input logic [7:0] b);
        return (b == PAT_MAX) ? PAT_MIN : b + 8'd1;
    endfunction

endpackage

// File: rtl/serdes_pat_checker_if.sv
// RX word bus between the SERDES receive side (master) and the pattern checker (slave).
interface serdes_pat_checker_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] rx_data_i;
    logic              rx_valid_i;
    logic              cnt_clr_i;
    logic              lock_o;
    logic              err_o;
    logic [CNT_W-1:0]  err_cnt_o;
    logic              rx_slide_o;

    modport master (
        output rx_data_i, rx_valid_i, cnt_clr_i,
        input  lock_o, err_o, err_cnt_o, rx_slide_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, cnt_clr_i,
        output lock_o, err_o, err_cnt_o, rx_slide_o
    );
endinterface

// File: rtl/serdes_pat_gen.sv
// Expected-word generator: from a starting byte P builds the N-byte word and the next P.
module serdes_pat_gen
    import serdes_lb_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [7:0]        p_i,
    output logic [DATA_W-1:0] word_o,
    output logic [7:0]        p_next_o
);
    localparam int N = DATA_W / 8;

    logic [7:0] b;

    always_comb begin
        b      = p_i;
        word_o = '0;
        for (int i = 0; i < N; i++) begin
            word_o[8*i +: 8] = b;
            b                = nxt_byte(b);
        end
        p_next_o = b;
    end
endmodule

// File: rtl/serdes_pat_checker.sv
// RX checker for the incrementing byte pattern: aligns, locks, counts errored words.
// Optional slip requests while hunting are enabled with SERDES_PATCHK_SLIDE_EN.
module serdes_pat_checker
    import serdes_lb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 4,
    parameter int CNT_W      = 16,
    parameter int SLIDE_WAIT = 64
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    serdes_pat_checker_if.slave  bus
);
    localparam int N = DATA_W / 8;
    localparam logic [1:0] ST_HUNT   = HUNT;
    localparam logic [1:0] ST_VERIFY = VERIFY;
    localparam logic [1:0] ST_LOCKED = LOCKED;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q;
    logic [7:0]        p_q;
    logic [7:0]        good_q;
    logic [7:0]        bad_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              lock_q;
    logic              err_q;

    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] exp_word;
    logic [7:0]        p_adv;
    logic [7:0]        hunt_p;
    logic              consistent;
    logic              match;
    logic              lock_err;

    serdes_pat_gen #(.DATA_W(DATA_W)) u_gen (
        .p_i      (p_q),
        .word_o   (exp_word),
        .p_next_o (p_adv)
    );

    assign rx_word  = bus.rx_data_i;
    assign match    = (rx_word == exp_word);
    assign hunt_p   = nxt_byte(rx_word[DATA_W-1 -: 8]);
    assign lock_err = bus.rx_valid_i && (state_q == ST_LOCKED) && !match;

    // A candidate word must be a self-consistent run of the pattern on its own.
    always_comb begin
        consistent = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (rx_word[8*i +: 8] < PAT_MIN || rx_word[8*i +: 8] > PAT_MAX)
                consistent = 1'b0;
            if (i < N - 1 && rx_word[8*(i+1) +: 8] != nxt_byte(rx_word[8*i +: 8]))
                consistent = 1'b0;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
            p_q     <= PAT_MIN;
            good_q  <= '0;
            bad_q   <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.rx_valid_i) begin
                case (state_q)
                    ST_HUNT: begin
                        if (consistent) begin
                            p_q    <= hunt_p;
                            good_q <= 8'd1;
                            bad_q  <= '0;
                            if (LOCK_CNT == 1) begin
                                state_q <= ST_LOCKED;
                                lock_q  <= 1'b1;
                            end else begin
                                state_q <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (match) begin
                            p_q    <= p_adv;
                            good_q <= good_q + 8'd1;
                            if (good_q + 8'd1 == 8'(LOCK_CNT)) begin
                                state_q <= ST_LOCKED;
                                lock_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        // Prediction free-runs in lock; errors never re-align it.
                        p_q <= p_adv;
                        if (!match) begin
                            err_q <= 1'b1;
                            bad_q <= bad_q + 8'd1;
                            if (bad_q + 8'd1 == 8'(LOSS_CNT)) begin
                                state_q <= ST_HUNT;
                                lock_q  <= 1'b0;
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst || bus.cnt_clr_i)
            cnt_q <= '0;
        else if (lock_err && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

`ifdef SERDES_PATCHK_SLIDE_EN
    localparam int MISS_W = $clog2(SLIDE_WAIT + 1);

    logic [MISS_W-1:0] miss_q;
    logic              slide_q;

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            miss_q  <= '0;
            slide_q <= 1'b0;
        end else begin
            slide_q <= 1'b0;
            if (state_q != ST_HUNT) begin
                miss_q <= '0;
            end else if (bus.rx_valid_i) begin
                if (consistent) begin
                    miss_q <= '0;
                end else if (miss_q == MISS_W'(SLIDE_WAIT - 1)) begin
                    miss_q  <= '0;
                    slide_q <= 1'b1;
                end else begin
                    miss_q <= miss_q + 1'b1;
                end
            end
        end
    end

    assign bus.rx_slide_o = slide_q;
`else
    localparam int unused_slide_wait = SLIDE_WAIT;
    assign bus.rx_slide_o = 1'b0;
`endif

    assign bus.lock_o    = lock_q;
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = cnt_q;
endmodule

// File: tb/tb_serdes_pat_checker.sv
// Randomized bench for serdes_pat_checker against a behavioural pattern model (16-bit words).
module tb_serdes_pat_checker;

    logic clk;
    logic rst;

    serdes_pat_checker_if #(.DATA_W(16), .CNT_W(16)) bus16 ();
    serdes_pat_checker_if #(.DATA_W(16), .CNT_W(4))  bus4 ();

    serdes_pat_checker #(.DATA_W(16), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(16), .SLIDE_WAIT(64)) dut (
        .rx_clk (clk),
        .rst    (rst),
        .bus    (bus16.slave)
    );

    serdes_pat_checker #(.DATA_W(16), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(4), .SLIDE_WAIT(64)) dut_sat (
        .rx_clk (clk),
        .rst    (rst),
        .bus    (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: mode 0=hunting, 1=verifying, 2=locked.
    int m_mode, m_p, m_good, m_bad, m_miss, m_cnt, m_cnt4;
    bit m_err, m_slide;
    int slides_seen;

    function automatic int nb(input int b);
        return (b % 8) + 1;
    endfunction

    function automatic logic [15:0] exp_word(input int p);
        return {8'(nb(p)), 8'(p)};
    endfunction

    function automatic bit is_cons(input logic [15:0] w);
        int lo, hi;
        lo = int'(w[7:0]);
        hi = int'(w[15:8]);
        return (lo >= 1 && lo <= 8 && hi == nb(lo));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_p = 1; m_good = 0; m_bad = 0; m_miss = 0;
        m_cnt = 0; m_cnt4 = 0; m_err = 0; m_slide = 0;
    endtask

    task automatic model_step(input logic [15:0] d, input bit v, input bit c);
        m_err   = 0;
        m_slide = 0;
        if (c) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end
        if (!v) return;
        case (m_mode)
            0: begin
                if (is_cons(d)) begin
                    m_p = nb(int'(d[15:8])); m_good = 1; m_bad = 0; m_mode = 1; m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == 64) begin
                        m_miss = 0;
`ifdef SERDES_PATCHK_SLIDE_EN
                        m_slide = 1;
`endif
                    end
                end
            end
            1: begin
                if (d == exp_word(m_p)) begin
                    m_p = nb(nb(m_p));
                    m_good++;
                    if (m_good == 4) m_mode = 2;
                end else begin
                    m_mode = 0;
                end
            end
            default: begin
                if (d != exp_word(m_p)) begin
                    m_err = 1;
                    if (!c) begin
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt4 < 15) m_cnt4++;
                    end
                    m_bad++;
                    if (m_bad == 4) m_mode = 0;
                end else begin
                    m_bad = 0;
                end
                m_p = nb(nb(m_p));
            end
        endcase
    endtask

    // Local pattern source: g_b is the next byte the transmitter would send.
    int g_b = 1;

    function automatic logic [15:0] pat_word();
        logic [15:0] w;
        w   = {8'(nb(g_b)), 8'(g_b)};
        g_b = nb(nb(g_b));
        return w;
    endfunction

    task automatic step(input logic [15:0] d, input bit v, input bit c, input bit r);
        @(negedge clk);
        rst = r;
        bus16.rx_data_i = d; bus16.rx_valid_i = v; bus16.cnt_clr_i = c;
        bus4.rx_data_i  = d; bus4.rx_valid_i  = v; bus4.cnt_clr_i  = c;
        if (r) model_reset();
        else   model_step(d, v, c);
        @(posedge clk);
        #1;
        chk("lock",        64'(bus16.lock_o),     64'(m_mode == 2));
        chk("err",         64'(bus16.err_o),      64'(m_err));
        chk("err_cnt",     64'(bus16.err_cnt_o),  64'(m_cnt));
        chk("err_cnt_sat", 64'(bus4.err_cnt_o),   64'(m_cnt4));
        chk("slide",       64'(bus16.rx_slide_o), 64'(m_slide));
        if (bus16.rx_slide_o) slides_seen++;
    endtask

    initial begin
        rst = 1'b1;
        bus16.rx_data_i = '0; bus16.rx_valid_i = 1'b0; bus16.cnt_clr_i = 1'b0;
        bus4.rx_data_i  = '0; bus4.rx_valid_i  = 1'b0; bus4.cnt_clr_i  = 1'b0;
        model_reset();

        step(16'h0, 0, 0, 1);
        step(16'h0, 0, 0, 1);

        // Aligned stream from 0201: lock after the fourth word.
        g_b = 1;
        for (int i = 0; i < 4; i++) step(pat_word(), 1, 0, 0);
        chk("lock_after_4", 64'(bus16.lock_o), 64'd1);
        for (int i = 0; i < 4; i++) step(pat_word(), 1, 0, 0);

        // Single corrupted word, then the stream continues.
        step(pat_word() ^ 16'h0010, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(pat_word(), 1, 0, 0);

        // Four zero words drop lock; the stream relocks.
        for (int i = 0; i < 4; i++) begin
            step(16'h0000, 1, 0, 0);
            void'(pat_word());
        end
        chk("unlock_after_4", 64'(bus16.lock_o), 64'd0);
        for (int i = 0; i < 6; i++) step(pat_word(), 1, 0, 0);

        // Byte-rotated start, with a valid gap mid-stream.
        g_b = 2;
        for (int i = 0; i < 5; i++) step(pat_word(), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(16'($urandom), 0, 0, 0);
        for (int i = 0; i < 5; i++) step(pat_word(), 1, 0, 0);

        // Build err_cnt to 7, then clear in the same cycle as an error.
        step(16'h0, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(pat_word() ^ 16'h0100, 1, 0, 0);
            step(pat_word(), 1, 0, 0);
        end
        step(pat_word() ^ 16'h0001, 1, 1, 0);
        chk("clr_wins", 64'(bus16.err_cnt_o), 64'd0);

        // Twenty errors saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            step(pat_word() ^ 16'h8000, 1, 0, 0);
            step(pat_word(), 1, 0, 0);
        end
        chk("sat_at_15", 64'(bus4.err_cnt_o), 64'd15);

        // Random traffic: gaps, corruption, misalignment, clears and resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                step(16'($urandom), 0, 1'($urandom_range(0, 19) == 0), 0);
            end else if (r < 22) begin
                step(pat_word() ^ 16'($urandom), 1, 1'($urandom_range(0, 19) == 0), 0);
            end else if (r < 25) begin
                g_b = int'($urandom_range(1, 8));
                step(pat_word(), 1, 0, 0);
            end else if (r < 26) begin
                step(16'h0, 1, 0, 1);
            end else begin
                step(pat_word(), 1, 1'($urandom_range(0, 49) == 0), 0);
            end
        end

        // Bit-shifted pattern never aligns: slip requests every 64 valid words.
        step(16'h0, 0, 0, 1);
        slides_seen = 0;
        g_b = 1;
        for (int i = 0; i < 140; i++) step(pat_word() << 1, 1, 0, 0);
`ifdef SERDES_PATCHK_SLIDE_EN
        chk("slide_pulses", 64'(slides_seen), 64'd2);
`else
        chk("slide_pulses", 64'(slides_seen), 64'd0);
`endif

        // Reset while locked.
        g_b = 3;
        for (int i = 0; i < 6; i++) step(pat_word(), 1, 0, 0);
        step(pat_word() ^ 16'h0002, 1, 0, 0);
        step(16'h0, 0, 0, 1);
        chk("reset_lock", 64'(bus16.lock_o), 64'd0);
        chk("reset_cnt",  64'(bus16.err_cnt_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
